// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: drives a multi-cycle req/ack data bus, steers store lanes,
// aligns and extends load data, and stalls the pipeline while an access is outstanding.
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] load_data_o,
    output logic        done_o,
    output logic        fault_o,
    output logic        timeout_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic [31:0] bus_rdata_i,
    input  logic        bus_ack_i
);

    localparam int unsigned CNT_W = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               we_q, we_d;
    logic [31:0]        addr_q, addr_d;
    logic [3:0]         be_q, be_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [2:0]         funct3_q, funct3_d;
    logic               to_q, to_d;
    logic [31:0]        load_data_q, load_data_d;

    logic               access;
    logic               illegal;
    logic [3:0]         be_c;
    logic [31:0]        wdata_c;
    logic [7:0]         rd_byte;
    logic [15:0]        rd_half;
    logic [31:0]        rd_ext;

    // Legality check and store lane steering for the instruction presented in IDLE
    always_comb begin
        access  = mem_read_i | mem_write_i;
        illegal = 1'b0;
        if (mem_write_i) begin
            if (funct3_i >= 3'b011) illegal = 1'b1;
        end else if (funct3_i == 3'b011 || funct3_i[2:1] == 2'b11) begin
            illegal = 1'b1;
        end
        if (funct3_i[1:0] == 2'b01 && addr_i[0]) illegal = 1'b1;
        if (funct3_i[1:0] == 2'b10 && addr_i[1:0] != 2'b00) illegal = 1'b1;

        case (funct3_i[1:0])
            2'b00: begin
                be_c    = 4'b0001 << addr_i[1:0];
                wdata_c = {4{wdata_i[7:0]}};
            end
            2'b01: begin
                be_c    = addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_c = {2{wdata_i[15:0]}};
            end
            default: begin
                be_c    = 4'b1111;
                wdata_c = wdata_i;
            end
        endcase
    end

    // Load alignment and sign/zero extension from the latched access
    always_comb begin
        rd_byte = bus_rdata_i[{addr_q[1:0], 3'b000} +: 8];
        rd_half = bus_rdata_i[{addr_q[1], 4'b0000} +: 16];
        case (funct3_q)
            3'b000:  rd_ext = {{24{rd_byte[7]}}, rd_byte};
            3'b100:  rd_ext = {24'd0, rd_byte};
            3'b001:  rd_ext = {{16{rd_half[15]}}, rd_half};
            3'b101:  rd_ext = {16'd0, rd_half};
            default: rd_ext = bus_rdata_i;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        be_d        = be_q;
        wdata_d     = wdata_q;
        funct3_d    = funct3_q;
        to_d        = to_q;
        load_data_d = load_data_q;
        stall_o     = 1'b0;
        fault_o     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                to_d  = 1'b0;
                if (access) begin
                    if (illegal) begin
                        fault_o     = 1'b1;
                        load_data_d = '0;
                    end else begin
                        we_d     = mem_write_i;
                        addr_d   = addr_i;
                        be_d     = be_c;
                        wdata_d  = wdata_c;
                        funct3_d = funct3_i;
                        stall_o  = 1'b1;
                        state_d  = WAIT;
                    end
                end
            end
            WAIT: begin
                stall_o = 1'b1;
                if (bus_ack_i) begin
                    if (!we_q) load_data_d = rd_ext;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    to_d        = 1'b1;
                    load_data_d = '0;
                    state_d     = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (rst_i) begin
            stall_o = 1'b0;
            fault_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            be_q        <= '0;
            wdata_q     <= '0;
            funct3_q    <= '0;
            to_q        <= 1'b0;
            load_data_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            be_q        <= be_d;
            wdata_q     <= wdata_d;
            funct3_q    <= funct3_d;
            to_q        <= to_d;
            load_data_q <= load_data_d;
        end
    end

    assign bus_req_o   = (state_q == WAIT);
    assign bus_we_o    = we_q;
    assign bus_addr_o  = {addr_q[31:2], 2'b00};
    assign bus_wdata_o = wdata_q;
    assign bus_be_o    = be_q;
    assign done_o      = (state_q == RESP) && !rst_i;
    assign timeout_o   = done_o && to_q;
    assign load_data_o = load_data_q;

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Scoreboard bench for mem_stage_lsu: stimulus pushes expected bus/response records,
// a negedge monitor pops and compares whenever the DUT requests the bus or pulses done/fault.
module tb_mem_stage_lsu;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o, done_o, fault_o, timeout_o;
    logic [31:0] load_data_o;
    logic        bus_req_o, bus_we_o;
    logic [31:0] bus_addr_o, bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic [31:0] bus_rdata_i;
    logic        bus_ack_i;

    always #5 clk_i = ~clk_i;

    mem_stage_lsu #(.TIMEOUT(4)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .mem_read_i  (mem_read_i),
        .mem_write_i (mem_write_i),
        .funct3_i    (funct3_i),
        .addr_i      (addr_i),
        .wdata_i     (wdata_i),
        .stall_o     (stall_o),
        .load_data_o (load_data_o),
        .done_o      (done_o),
        .fault_o     (fault_o),
        .timeout_o   (timeout_o),
        .bus_req_o   (bus_req_o),
        .bus_we_o    (bus_we_o),
        .bus_addr_o  (bus_addr_o),
        .bus_wdata_o (bus_wdata_o),
        .bus_be_o    (bus_be_o),
        .bus_rdata_i (bus_rdata_i),
        .bus_ack_i   (bus_ack_i)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        chk_be;
        int          len;
    } bus_exp_t;

    typedef struct {
        logic        done;
        logic        tmo;
        logic        fault;
        logic        chk_data;
        logic [31:0] data;
        int          stall;
    } rsp_exp_t;

    bus_exp_t bq[$];
    rsp_exp_t rq[$];
    int n_pass  = 0;
    int n_total = 0;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endfunction

    // Monitor
    bus_exp_t cur;
    rsp_exp_t r;
    logic     have_cur  = 1'b0;
    logic     req_prev  = 1'b0;
    int       req_len   = 0;
    int       stall_run = 0;

    initial begin
        forever begin
            @(negedge clk_i);
            if (bus_req_o && !req_prev) begin
                req_len = 0;
                if (bq.size() == 0) begin
                    check("unexpected_req", 32'd1, 32'd0);
                    have_cur = 1'b0;
                end else begin
                    cur = bq.pop_front();
                    have_cur = 1'b1;
                    check("bus_we", 32'(bus_we_o), 32'(cur.we));
                    check("bus_addr", bus_addr_o, cur.addr);
                    if (cur.we) check("bus_wdata", bus_wdata_o, cur.wdata);
                    if (cur.chk_be) check("bus_be", 32'(bus_be_o), 32'(cur.be));
                end
            end
            if (bus_req_o) req_len++;
            if (!bus_req_o && req_prev && have_cur) begin
                if (cur.len >= 0) check("req_len", 32'(req_len), 32'(cur.len));
                have_cur = 1'b0;
            end
            if (done_o || fault_o) begin
                if (rq.size() == 0) begin
                    check("unexpected_pulse", 32'd1, 32'd0);
                end else begin
                    r = rq.pop_front();
                    check("done", 32'(done_o), 32'(r.done));
                    check("fault", 32'(fault_o), 32'(r.fault));
                    check("timeout", 32'(timeout_o), 32'(r.tmo));
                    check("stall_cycles", 32'(stall_run), 32'(r.stall));
                    if (fault_o) check("fault_no_stall", 32'(stall_o), 32'd0);
                    if (r.chk_data) check("load_data", load_data_o, r.data);
                end
            end
            stall_run = stall_o ? stall_run + 1 : 0;
            req_prev  = bus_req_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_bus(input logic we, input logic [31:0] addr, input logic [3:0] be,
                            input logic [31:0] wd, input logic chk_be, input int len);
        bus_exp_t e;
        e.we = we; e.addr = addr; e.be = be; e.wdata = wd; e.chk_be = chk_be; e.len = len;
        bq.push_back(e);
    endtask

    task automatic push_rsp(input logic tmo, input logic fault, input logic chk,
                            input logic [31:0] data, input int stall);
        rsp_exp_t e;
        e.done = !fault; e.tmo = tmo; e.fault = fault; e.chk_data = chk; e.data = data;
        e.stall = stall;
        rq.push_back(e);
    endtask

    // Issue an access and ack it k cycles into WAIT (k >= 4 means never ack)
    task automatic access(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wd, input int k,
                          input logic [31:0] rdata);
        mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = addr; wdata_i = wd;
        tick();
        for (int j = 0; j < 4; j++) begin
            if (j == k) begin
                bus_ack_i   = 1'b1;
                bus_rdata_i = rdata;
            end
            tick();
            bus_ack_i = 1'b0;
            if (j == k) break;
        end
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        tick();
    endtask

    task automatic illegal_access(input logic rd, input logic wr, input logic [2:0] f3,
                                  input logic [31:0] addr);
        push_rsp(1'b0, 1'b1, 1'b0, 32'd0, 0);
        mem_read_i = rd; mem_write_i = wr; funct3_i = f3; addr_i = addr; wdata_i = 32'hFFFF_FFFF;
        tick();
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        check("fault_clears_load_data", load_data_o, 32'd0);
        check("fault_no_req", 32'(bus_req_o), 32'd0);
    endtask

    initial begin
        rst_i = 1'b1;
        mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b010;
        addr_i = 32'h100; wdata_i = '0; bus_rdata_i = '0; bus_ack_i = 1'b0;
        tick();
        tick();
        check("rst_stall", 32'(stall_o), 32'd0);
        check("rst_req", 32'(bus_req_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_fault", 32'(fault_o), 32'd0);
        check("rst_load_data", load_data_o, 32'd0);
        mem_read_i = 1'b0;
        rst_i = 1'b0;
        tick();
        tick();

        // LW with ack three cycles into WAIT
        push_bus(1'b0, 32'h100, 4'b1111, 32'd0, 1'b1, 4);
        push_rsp(1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 5);
        access(1'b1, 1'b0, 3'b010, 32'h100, 32'd0, 3, 32'hDEADBEEF);

        push_bus(1'b0, 32'h100, 4'b0000, 32'd0, 1'b0, 1);
        push_rsp(1'b0, 1'b0, 1'b1, 32'hFFFFFF80, 2);
        access(1'b1, 1'b0, 3'b000, 32'h103, 32'd0, 0, 32'h80FF7F01);

        push_bus(1'b0, 32'h100, 4'b0000, 32'd0, 1'b0, 1);
        push_rsp(1'b0, 1'b0, 1'b1, 32'h00000080, 2);
        access(1'b1, 1'b0, 3'b100, 32'h103, 32'd0, 0, 32'h80FF7F01);

        push_bus(1'b0, 32'h100, 4'b0000, 32'd0, 1'b0, 1);
        push_rsp(1'b0, 1'b0, 1'b1, 32'hFFFF80FF, 2);
        access(1'b1, 1'b0, 3'b001, 32'h102, 32'd0, 0, 32'h80FF7F01);

        push_bus(1'b0, 32'h100, 4'b0000, 32'd0, 1'b0, 1);
        push_rsp(1'b0, 1'b0, 1'b1, 32'h000080FF, 2);
        access(1'b1, 1'b0, 3'b101, 32'h102, 32'd0, 0, 32'h80FF7F01);

        // Stores: SB, SH, SW, and write priority when both strobes are high
        push_bus(1'b1, 32'h100, 4'b0010, 32'h78787878, 1'b1, 1);
        push_rsp(1'b0, 1'b0, 1'b0, 32'd0, 2);
        access(1'b0, 1'b1, 3'b000, 32'h101, 32'h12345678, 0, 32'd0);

        push_bus(1'b1, 32'h100, 4'b1100, 32'hABCDABCD, 1'b1, 1);
        push_rsp(1'b0, 1'b0, 1'b0, 32'd0, 2);
        access(1'b0, 1'b1, 3'b001, 32'h102, 32'h0000ABCD, 0, 32'd0);

        push_bus(1'b1, 32'h104, 4'b1111, 32'hCAFEF00D, 1'b1, 2);
        push_rsp(1'b0, 1'b0, 1'b0, 32'd0, 3);
        access(1'b0, 1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 1, 32'd0);

        push_bus(1'b1, 32'h108, 4'b1111, 32'h11223344, 1'b1, 1);
        push_rsp(1'b0, 1'b0, 1'b0, 32'd0, 2);
        access(1'b1, 1'b1, 3'b010, 32'h108, 32'h11223344, 0, 32'h55555555);

        // Illegal accesses
        illegal_access(1'b0, 1'b1, 3'b010, 32'h102);
        illegal_access(1'b1, 1'b0, 3'b001, 32'h101);
        illegal_access(1'b1, 1'b0, 3'b011, 32'h100);
        illegal_access(1'b0, 1'b1, 3'b011, 32'h100);
        tick();
        tick();

        // Timeout with no ack, then a stale ack that must be ignored
        push_bus(1'b0, 32'h200, 4'b1111, 32'd0, 1'b1, 4);
        push_rsp(1'b1, 1'b0, 1'b1, 32'd0, 5);
        access(1'b1, 1'b0, 3'b010, 32'h200, 32'd0, 9, 32'd0);
        bus_ack_i = 1'b1; bus_rdata_i = 32'h0BADF00D;
        tick();
        bus_ack_i = 1'b0;
        tick();
        check("stale_ack_req", 32'(bus_req_o), 32'd0);
        check("stale_ack_data", load_data_o, 32'd0);

        // Reset during the second WAIT cycle abandons the access
        push_bus(1'b0, 32'h300, 4'b1111, 32'd0, 1'b1, -1);
        mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h300;
        tick();
        tick();
        rst_i = 1'b1;
        mem_read_i = 1'b0;
        tick();
        check("rst_wait_req", 32'(bus_req_o), 32'd0);
        check("rst_wait_done", 32'(done_o), 32'd0);
        rst_i = 1'b0;
        tick();

        push_bus(1'b0, 32'h300, 4'b1111, 32'd0, 1'b1, 3);
        push_rsp(1'b0, 1'b0, 1'b1, 32'h13579BDF, 4);
        access(1'b1, 1'b0, 3'b010, 32'h300, 32'd0, 2, 32'h13579BDF);

        tick();
        tick();
        check("bus_queue_drained", 32'(bq.size()), 32'd0);
        check("rsp_queue_drained", 32'(rq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
